dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the load unit and the store-commit buffer.
//  Grants at most one access per cycle and checks alignment and bounds before the memory sees an access.
//  Returns load data through a one-entry registered response with backpressure.
//  Sits between the LSU front end and datamem; datamem reads are combinational and writes land on posedge.
// PARAMETERS
//  TAG_W         4     width of the load tag echoed on the response
//  STARVE_LIMIT  4     cycles a pending store may lose arbitration before it is forced through (>=1)
//  MEM_BYTES     1024  data memory size in bytes; power of two, >8
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  ld_valid       in   1      load request valid
//  ld_ready       out  1      load request accepted this cycle when ld_valid is also high
//  ld_addr        in   64     load byte address
//  ld_size        in   4      load size in bytes: 1/2/4/8
//  ld_tag         in   TAG_W  load identifier
//  st_valid       in   1      store request valid
//  st_ready       out  1      store accepted this cycle when st_valid is also high
//  st_addr        in   64     store byte address
//  st_size        in   4      store size in bytes
//  st_data        in   64     store data, little-endian, low bytes used
//  st_err         out  1      one-cycle pulse, registered: the previous accepted store was illegal and was dropped
//  rsp_valid      out  1      load response valid
//  rsp_ready      in   1      consumer accepts the response
//  rsp_tag        out  TAG_W  tag of the responding load
//  rsp_data       out  64     load data, zero-extended above size
//  rsp_err        out  1      load was illegal; rsp_data is 0
//  mem_address    out  64     to datamem.address
//  mem_we         out  1      to datamem.write_enable
//  mem_re         out  1      to datamem.read_enable
//  mem_wdata      out  64     to datamem.write_data
//  mem_size       out  4      to datamem.xfer_size
//  mem_rdata      in   64     from datamem.read_data, valid in the same cycle
// BEHAVIOUR
//  Reset
//   - rsp_valid, rsp_err, st_err, rsp_tag, rsp_data: 0.
//   - Starve counter: 0.
//   - While reset is high: ld_ready=st_ready=0 and mem_we=mem_re=0.
//  Legality (dmem_align_check)
//   - size is in {1,2,4,8};
//   - (addr & (size-1)) == 0;
//   - addr + size <= MEM_BYTES, computed at 65 bits so it cannot wrap.
//  Load slot availability
//   - ld_slot_free = !rsp_valid || rsp_ready. The response register may be refilled in the same cycle it drains.
//  Arbitration, combinational, one grant per cycle
//   - force_st = st_valid && (starve_cnt == STARVE_LIMIT).
//   - st_ready = st_valid && (force_st || !(ld_valid && ld_slot_free)).
//   - ld_ready = ld_slot_free && !st_ready.
//   - Load wins by default. A store never waits more than STARVE_LIMIT cycles while it is eligible.
//  Starve counter
//   - Increments, saturating at STARVE_LIMIT, on cycles where st_valid && !st_ready.
//   - Clears on a store grant or when st_valid is low.
//  Memory drive, same cycle as grant
//   - Legal store: mem_we=1 with mem_address=st_addr, mem_wdata=st_data, mem_size=st_size.
//   - Legal load: mem_re=1 with mem_address=ld_addr, mem_size=ld_size.
//   - Illegal request or no grant: mem_we=mem_re=0, mem_address=0, mem_size=8.
//  Load latency
//   - Exactly 1 cycle: on the cycle after the grant, rsp_valid=1.
//   - rsp_data = mem_rdata masked to ld_size, or 0 if illegal; rsp_tag = the granted tag.
//   - Response fields hold stable until rsp_valid && rsp_ready.
//  Store completion
//   - No response. Data is written at the grant edge.
//   - An illegal store is consumed (st_ready=1) and st_err pulses the next cycle.
//  Simultaneous events
//   - Load and store both valid with the slot blocked: store granted.
//   - Response drains while a new load is granted: the new response replaces it with no bubble.
//  Reset mid-operation
//   - A pending response is discarded and the counter clears.
//   - A store granted in the reset cycle is not written.
// STRUCTURE
//  Package dmem_pkg
//   - localparam DMEM_BYTES = 1024.
//   - typedef logic [3:0] xfer_size_t.
//   - Constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8.
//   - function size_mask(xfer_size_t) returning a 64-bit byte mask.
//  Sub-module dmem_align_check
//   - Combinational: addr and size in, legal out. Instantiated once for the load path, once for the store path.
// TESTING (bench attaches the real datamem)
//  1. Store 0x1122334455667788 to addr 0x10 size 8, then load 0x10 size 8 tag 3 -> next cycle rsp_valid, rsp_data=0x1122334455667788, rsp_tag=3.
//  2. ld_valid and st_valid held high continuously, STARVE_LIMIT=4 -> loads granted 4 cycles, store granted on the 5th, pattern repeats.
//  3. Load addr 0x12 size 4 -> rsp_err=1, rsp_data=0, mem_re never high. Store addr 1020 size 8 -> st_err pulse, memory unchanged.
//  4. rsp_ready low for 3 cycles with ld_valid high -> ld_ready=0 during the stall, rsp fields stable, stores still granted.
//  5. Load byte at 0x17 after storing 0xAB at 0x17 -> rsp_data=0x00000000000000AB (upper bytes zeroed).
//  6. Reset asserted one cycle after a load grant -> rsp_valid=0 the next cycle, no response is ever delivered for that tag.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory port types and constants.
// Used by the arbiter and its alignment checker.
package dmem_pkg;

  localparam int DMEM_BYTES = 1024;

  typedef logic [3:0] xfer_size_t;

  localparam xfer_size_t SZ_B = 4'd1;
  localparam xfer_size_t SZ_H = 4'd2;
  localparam xfer_size_t SZ_W = 4'd4;
  localparam xfer_size_t SZ_D = 4'd8;

  function automatic logic [63:0] size_mask(
    input xfer_size_t size
  );
    logic [63:0] m;
    m = '1;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00ff;
      SZ_H:    m = 64'h0000_0000_0000_ffff;
      SZ_W:    m = 64'h0000_0000_ffff_ffff;
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Size, natural-alignment and bounds check for one
// data-memory request.
module dmem_align_check
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic [63:0] addr,
  input  xfer_size_t  size,
  output logic        legal
);

  logic        size_ok;
  logic        align_ok;
  logic        bound_ok;
  logic [64:0] end_addr;

  always_comb begin
    size_ok  = (size == SZ_B) || (size == SZ_H) ||
               (size == SZ_W) || (size == SZ_D);
    // size <= 8, so only the low nibble can be misaligned
    align_ok = (addr[3:0] & (size - 4'd1)) == 4'd0;
    end_addr = {1'b0, addr} + {61'd0, size};
    bound_ok = end_addr <= 65'(MEM_BYTES);
    legal    = size_ok && align_ok && bound_ok;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Load/store arbiter in front of the single-port datamem,
// with a one-entry registered load response.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_BYTES    = DMEM_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [63:0]      ld_addr,
  input  logic [3:0]       ld_size,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [63:0]      st_addr,
  input  logic [3:0]       st_size,
  input  logic [63:0]      st_data,
  output logic             st_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [63:0]      rsp_data,
  output logic             rsp_err,
  output logic [63:0]      mem_address,
  output logic             mem_we,
  output logic             mem_re,
  output logic [63:0]      mem_wdata,
  output logic [3:0]       mem_size,
  input  logic [63:0]      mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STARVE_LIMIT);

  logic             ld_legal;
  logic             st_legal;
  logic             slot_free;
  logic             force_st;
  logic             ld_gnt;
  logic             st_go;
  logic             ld_go;

  logic             rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             st_err_q, st_err_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  dmem_align_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ld_chk (
    .addr  (ld_addr),
    .size  (ld_size),
    .legal (ld_legal)
  );

  dmem_align_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_st_chk (
    .addr  (st_addr),
    .size  (st_size),
    .legal (st_legal)
  );

  // Loads win unless the store has waited STARVE_LIMIT cycles
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    force_st  = st_valid && (starve_q == CNT_MAX);
    st_ready  = !reset && st_valid &&
                (force_st || !(ld_valid && slot_free));
    ld_ready  = !reset && slot_free && !st_ready;
    ld_gnt    = ld_valid && ld_ready;
    st_go     = st_ready && st_legal;
    ld_go     = ld_gnt && ld_legal;
  end

  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_size    = SZ_D;
    unique case (1'b1)
      st_go: begin
        mem_we      = 1'b1;
        mem_address = st_addr;
        mem_wdata   = st_data;
        mem_size    = st_size;
      end
      ld_go: begin
        mem_re      = 1'b1;
        mem_address = ld_addr;
        mem_size    = ld_size;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (ld_gnt) begin
      rsp_valid_d = 1'b1;
      rsp_tag_d   = ld_tag;
      rsp_data_d  = ld_legal ?
                    (mem_rdata & size_mask(ld_size)) :
                    64'd0;
      rsp_err_d   = !ld_legal;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    st_err_d = st_ready && !st_legal;
    starve_d = starve_q;
    if (!st_valid || st_ready) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      st_err_q    <= 1'b0;
      starve_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      st_err_q    <= st_err_d;
      starve_q    <= starve_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a
// behavioural datamem and reference memory image.
module tb_dmem_port_arbiter;

  localparam int TAG_W = 4;
  localparam int LIMIT = 4;
  localparam int MEMB  = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_valid, ld_ready;
  logic [63:0]      ld_addr;
  logic [3:0]       ld_size;
  logic [TAG_W-1:0] ld_tag;
  logic             st_valid, st_ready;
  logic [63:0]      st_addr;
  logic [3:0]       st_size;
  logic [63:0]      st_data;
  logic             st_err;
  logic             rsp_valid, rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [63:0]      rsp_data;
  logic             rsp_err;
  logic [63:0]      mem_address;
  logic             mem_we, mem_re;
  logic [63:0]      mem_wdata;
  logic [3:0]       mem_size;
  logic [63:0]      mem_rdata;

  dmem_port_arbiter #(
    .TAG_W        (TAG_W),
    .STARVE_LIMIT (LIMIT),
    .MEM_BYTES    (MEMB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_tag      (ld_tag),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_size     (st_size),
    .st_data     (st_data),
    .st_err      (st_err),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_wdata   (mem_wdata),
    .mem_size    (mem_size),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural datamem: combinational read of 8 bytes, posedge write
  logic [7:0] mem     [MEMB];
  logic [7:0] ref_mem [MEMB];

  always @* begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      mem_rdata[8*i +: 8] = mem[(int'(mem_address[9:0]) + i) % MEMB];
  end

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < int'(mem_size); i++)
        mem[(int'(mem_address[9:0]) + i) % MEMB] <= mem_wdata[8*i +: 8];
  end

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   pend     = 1'b0;
  int   waitc    = 0;
  bit   exp_st_err = 1'b0;
  int   st_gnts  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [63:0] a, input logic [3:0] s);
    if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b0;
    if (a % 64'(s) != 0) return 1'b0;
    return a <= 64'(MEMB - int'(s));
  endfunction

  task automatic step(input bit rst, input bit lv, input logic [63:0] la,
                      input logic [3:0] ls, input logic [TAG_W-1:0] lt,
                      input bit sv, input logic [63:0] sa,
                      input logic [3:0] ss, input logic [63:0] sd,
                      input bit rr);
    bit slot, sg, lg, sl, ll;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ld_valid = lv; ld_addr = la; ld_size = ls; ld_tag = lt;
    st_valid = sv; st_addr = sa; st_size = ss; st_data = sd;
    rsp_ready = rst ? 1'b0 : rr;
    #1;
    chk("st_err", st_err, exp_st_err);
    chk("rsp_valid", rsp_valid, pend);
    if (rst) begin
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_st_ready", st_ready, 0);
      chk("rst_mem_en", {mem_we, mem_re}, 0);
      pend = 1'b0; q.delete(); waitc = 0; exp_st_err = 1'b0;
    end else begin
      slot = !pend || rr;
      sg = sv && (waitc == LIMIT || !(lv && slot));
      lg = lv && slot && !sg;
      sl = legal(sa, ss);
      ll = legal(la, ls);
      chk("st_ready", st_ready, sg);
      chk("ld_ready", ld_ready, slot && !sg);
      chk("mem_we", mem_we, sg && sl);
      chk("mem_re", mem_re, lg && ll);
      if (sg && sl) begin
        chk("st_addr_out", mem_address, sa);
        chk("st_wdata_out", mem_wdata, sd);
        chk("st_size_out", mem_size, ss);
        for (int i = 0; i < int'(ss); i++)
          ref_mem[int'(sa[9:0]) + i] = sd[8*i +: 8];
      end else if (lg && ll) begin
        chk("ld_addr_out", mem_address, la);
        chk("ld_size_out", mem_size, ls);
      end else begin
        chk("idle_mem_out", {mem_address, mem_size}, {64'd0, 4'd8});
      end
      if (sg) st_gnts++;
      exp_st_err = sg && !sl;
      waitc = (sv && !sg) ? ((waitc < LIMIT) ? waitc + 1 : LIMIT) : 0;
      if (lg) begin
        e.tag = lt; e.err = !ll; e.data = '0;
        if (ll)
          for (int i = 0; i < int'(ls); i++)
            e.data[8*i +: 8] = ref_mem[int'(la[9:0]) + i];
        q.push_back(e);
        pend = 1'b1;
      end else if (rr) begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 8, 0, 0, 0, 8, 0, rr);
  endtask

  // Monitor: pops the scoreboard on each accepted response
  initial begin
    logic             pv, pr;
    logic [TAG_W+64:0] pf;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pf = '0;
    forever begin
      @(negedge clk);
      if (pv === 1'b1 && pr === 1'b0 && rsp_valid === 1'b1)
        chk("rsp_hold", {rsp_tag, rsp_data, rsp_err}, pf);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
        end
      end
      pv = rsp_valid; pr = rsp_ready;
      pf = {rsp_tag, rsp_data, rsp_err};
    end
  end

  function automatic logic [3:0] rand_size();
    case ($urandom_range(0, 9))
      0:       return 4'd3;
      1, 2:    return 4'd1;
      3, 4:    return 4'd2;
      5, 6:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] rand_addr(input logic [3:0] s);
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0:       a = 64'($urandom_range(1000, 1100));
      1:       a = {$urandom, $urandom};
      default: a = 64'($urandom_range(0, 127));
    endcase
    if ($urandom_range(0, 3) != 0 && s != 0) a = a & ~64'(s - 4'd1);
    return a;
  endfunction

  initial begin
    logic [3:0]  ls, ss;
    int          nbad;
    for (int i = 0; i < MEMB; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset = 1'b1; ld_valid = 0; ld_addr = 0; ld_size = 8; ld_tag = 0;
    st_valid = 0; st_addr = 0; st_size = 8; st_data = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {rsp_valid, rsp_err, st_err, rsp_tag, rsp_data}, 0);
    chk("reset_mem_en", {mem_we, mem_re}, 0);

    // 1: store dword, load it back
    step(0, 0, 0, 8, 0, 1, 64'h10, 8, 64'h1122334455667788, 1);
    step(0, 1, 64'h10, 8, 3, 0, 0, 8, 0, 1);
    idle(1);

    // 2: contention, store forced through every 5th cycle
    st_gnts = 0;
    for (int i = 0; i < 10; i++)
      step(0, 1, 64'h20, 8, 4'(i), 1, 64'h40 + 64'(8*i), 8,
           {$urandom, $urandom}, 1);
    chk("starve_store_grants", st_gnts, 2);
    idle(1); idle(1);

    // 3: illegal load/store, boundary and wrap cases
    step(0, 1, 64'h12, 4, 5, 0, 0, 8, 0, 1);
    step(0, 0, 0, 8, 0, 1, 64'd1020, 8, 64'hdeadbeefdeadbeef, 1);
    step(0, 0, 0, 8, 0, 1, 64'd1016, 8, 64'h0102030405060708, 1);
    step(0, 1, 64'hffff_ffff_ffff_fff8, 8, 6, 0, 0, 8, 0, 1);
    step(0, 1, 64'd1016, 8, 7, 0, 0, 8, 0, 1);
    idle(1);

    // 4: consumer stall, stores still flow
    step(0, 1, 64'h10, 4, 8, 0, 0, 8, 0, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 64'h18, 8, 9, 1, 64'h80 + 64'(8*i), 8,
           {$urandom, $urandom}, 0);
    idle(1); idle(1);

    // 5: byte store and zero-extended byte load
    step(0, 0, 0, 8, 0, 1, 64'h17, 1, 64'h00000000000000ab, 1);
    step(0, 1, 64'h17, 1, 10, 0, 0, 8, 0, 1);
    idle(1);

    // 6: reset right after a load grant discards the response
    step(0, 1, 64'h10, 8, 11, 0, 0, 8, 0, 1);
    step(1, 0, 0, 8, 0, 1, 64'h30, 8, 64'h5555aaaa5555aaaa, 0);
    idle(1); idle(1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      ls = rand_size();
      ss = rand_size();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           rand_addr(ls), ls, 4'($urandom),
           $urandom_range(0, 2) != 0, rand_addr(ss), ss,
           {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    repeat (4) idle(1);
    chk("rsp_drained", q.size(), 0);

    nbad = 0;
    for (int i = 0; i < MEMB; i++)
      if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
